// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: opcode and
// sequencer state encodings plus the default iteration count.
package muldiv;

  localparam int ITERATIONS = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_add.sv
// Ripple-style adder/subtractor shared by the multiply accumulate and the
// divide trial subtraction; carry_out is "no borrow" when subtracting.
module add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             neg_b_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = neg_b_in ? ~b_in : b_in;
  assign {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, neg_b_in};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// unsigned magnitudes, sign fix-up afterwards, result held until acknowledged.
module muldiv_sequencer #(
  parameter int ITERATIONS = muldiv::ITERATIONS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  muldiv::op_t       op_in,
  input  logic [31:0]       a_in,
  input  logic [31:0]       b_in,
  input  logic              flush_in,
  input  logic              ack_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [31:0]       result_out
);
  import muldiv::*;

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  state_t        state_reg;
  op_t           op_reg;
  logic          neg_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;
  logic [31:0]   b_reg;
  logic [31:0]   result_reg;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic        is_div, is_rem, div_zero, div_ovf, special, neg_next;
  logic [31:0] a_mag, b_mag, special_result;

  always_comb begin
    a_signed = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
    b_signed = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
    a_neg    = a_signed && a_in[31];
    b_neg    = b_signed && b_in[31];
    a_mag    = magnitude(a_in, a_signed);
    b_mag    = magnitude(b_in, b_signed);
    is_div   = op_in[2];
    is_rem   = op_in[2] && op_in[1];
    div_zero = is_div && (b_in == 32'd0);
    div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
               (a_in == 32'h8000_0000) && (b_in == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) special_result = is_rem ? a_in : 32'hFFFF_FFFF;
    else          special_result = is_rem ? 32'd0 : 32'h8000_0000;
    // One flag covers product, quotient or remainder depending on the op.
    case (op_in)
      MULH, DIV:   neg_next = a_neg ^ b_neg;
      MULHSU, REM: neg_next = a_neg;
      default:     neg_next = 1'b0;
    endcase
  end

  logic        div_op;
  logic [31:0] add_a, add_sum;
  logic        add_carry;

  assign div_op = op_reg[2];
  assign add_a  = div_op ? {hi_reg[30:0], lo_reg[31]} : hi_reg;

  add #(.WIDTH(32)) u_add (
    .a_in      (add_a),
    .b_in      (b_reg),
    .neg_b_in  (div_op),
    .sum_out   (add_sum),
    .carry_out (add_carry)
  );

  logic [32:0] mul_acc;
  logic        no_borrow;
  logic [31:0] div_rem;

  assign mul_acc   = lo_reg[0] ? {add_carry, add_sum} : {1'b0, hi_reg};
  // A set remainder MSB means the shifted value already exceeds any divisor.
  assign no_borrow = hi_reg[31] | add_carry;
  assign div_rem   = no_borrow ? add_sum : add_a;

  logic [63:0] prod_fix;
  logic [31:0] rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_reg ? (~{hi_reg, lo_reg} + 64'd1) : {hi_reg, lo_reg};
    rem_fix  = neg_reg ? (~hi_reg + 32'd1) : hi_reg;
    case (op_reg)
      MUL, DIV, DIVU:      fix_result = prod_fix[31:0];
      MULH, MULHSU, MULHU: fix_result = prod_fix[63:32];
      default:             fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op_reg     <= MUL;
      neg_reg    <= 1'b0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else if (flush_in) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            op_reg    <= op_in;
            neg_reg   <= neg_next;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= a_mag;
            b_reg     <= b_mag;
            if (special) begin
              result_reg <= special_result;
              state_reg  <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (div_op) begin
            hi_reg <= div_rem;
            lo_reg <= {lo_reg[30:0], no_borrow};
          end else begin
            hi_reg <= mul_acc[32:1];
            lo_reg <= {mul_acc[0], lo_reg[31:1]};
          end
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST) state_reg <= FIX;
        end
        FIX: begin
          result_reg <= fix_result;
          state_reg  <= DONE;
        end
        DONE: begin
          if (ack_in) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_out   = rst && (((state_reg == IDLE) && start_in && !flush_in) ||
                              (state_reg == CALC) || (state_reg == FIX));
  assign done_out   = (state_reg == DONE);
  assign result_out = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against a
// behavioural model, and hand sequences for flush, hold, and reset.
module tb_muldiv_sequencer;
  import muldiv::*;

  localparam int LAT = ITERATIONS + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  op_t         op_in = MUL;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        flush_in = 1'b0;
  logic        ack_in = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic [31:0] result_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.ITERATIONS(ITERATIONS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .op_in      (op_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .flush_in   (flush_in),
    .ack_in     (ack_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    int          hold;
    bit          flush_ack;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic bit is_special(input op_t op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p, ua, ub;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      MUL:    begin p = ua * ub; return p[31:0]; end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expected, input int hold, input bit flush_ack);
    int          cyc;
    int          lat_exp;
    bit          busy_bad;
    bit          special;
    logic [31:0] want;
    logic [31:0] got;
    special = is_special(op, a, b);
    lat_exp = special ? 1 : LAT;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    sb_q.push_back(expected);
    #1;
    check("busy_at_accept", 32'(busy_out), 32'd1);
    @(negedge clk);
    start_in = 1'b0;
    cyc      = 1;
    busy_bad = 1'b0;
    while (cyc < 100) begin
      if (busy_out !== ((!special) && (cyc <= LAT - 1))) busy_bad = 1'b1;
      if (done_out) break;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(lat_exp));
    check("busy_profile", 32'(busy_bad), 32'd0);
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    got  = result_out;
    check("result", got, want);
    $display("txn %-6s a=%h b=%h result=%h latency=%0d", op.name(), a, b, got, cyc);
    for (int h = 0; h < hold; h++) begin
      start_in = 1'b1;
      op_in    = MUL;
      a_in     = 32'd1;
      b_in     = 32'd1;
      @(negedge clk);
      check("hold_done", 32'(done_out), 32'd1);
      check("hold_result", result_out, want);
    end
    start_in = 1'b0;
    ack_in   = 1'b1;
    flush_in = flush_ack;
    @(negedge clk);
    ack_in   = 1'b0;
    flush_in = 1'b0;
    check("done_after_ack", 32'(done_out), 32'd0);
    check("result_kept_after_ack", result_out, want);
    last_result = want;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1'b0};
    vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0};
    vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0};
    vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 1'b0};
    vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 1'b0};
    vecs[6]  = '{DIVU,   32'd100,       32'd7,         32'd14,        0, 1'b0};
    vecs[7]  = '{REMU,   32'd100,       32'd7,         32'd2,         0, 1'b0};
    vecs[8]  = '{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1'b0};
    vecs[9]  = '{REM,    32'd5,         32'd0,         32'd5,         0, 1'b0};
    vecs[10] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0};
    vecs[11] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 1'b0};
    vecs[12] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0};
    vecs[13] = '{DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1'b0};
    vecs[14] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         3, 1'b0};
    vecs[15] = '{REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         0, 1'b1};

    // Reset state, with start_in held high to confirm busy stays low.
    start_in = 1'b1;
    #1;
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_done", 32'(done_out), 32'd0);
    check("reset_result", result_out, 32'd0);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_out), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expected, vecs[i].hold, vecs[i].flush_ack);

    for (int i = 0; i < 10; i++) begin
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      op = op_t'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
      run_op(op, a, b, model(op, a, b), 0, 1'b0);
    end

    // Flush in cycle 10 of a divide: nothing completes, old result stays.
    begin
      bit done_seen;
      @(negedge clk);
      start_in = 1'b1;
      op_in    = DIV;
      a_in     = 32'd1000;
      b_in     = 32'd7;
      @(negedge clk);
      start_in = 1'b0;
      repeat (9) @(negedge clk);
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      check("flush_busy", 32'(busy_out), 32'd0);
      check("flush_done", 32'(done_out), 32'd0);
      check("flush_result_kept", result_out, last_result);
      done_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done_out || busy_out) done_seen = 1'b1;
      end
      check("flush_no_late_done", 32'(done_seen), 32'd0);
      $display("txn flush  DIV squashed at cycle 10");
      run_op(MUL, 32'd3, 32'd4, 32'd12, 0, 1'b0);
    end

    // Reset mid-CALC clears outputs at once and leaves no partial result.
    begin
      bit activity;
      @(negedge clk);
      start_in = 1'b1;
      op_in    = MULHU;
      a_in     = 32'h1234_5678;
      b_in     = 32'h9ABC_DEF0;
      @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset_busy", 32'(busy_out), 32'd0);
      check("midreset_done", 32'(done_out), 32'd0);
      check("midreset_result", result_out, 32'd0);
      start_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      activity = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done_out || busy_out || (result_out != 32'd0)) activity = 1'b1;
      end
      check("midreset_quiet", 32'(activity), 32'd0);
      $display("txn reset  MULHU aborted during CALC");
      run_op(DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1, 1'b0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
